// File: rtl/s8_control_unit_pkg.sv
// Shared definitions for the S8 control unit: FSM state encoding, opcode map
// and ALU operation codes, plus small opcode-classification helpers.
package s8_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMOP  = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic [1:0] alu_for(input logic [3:0] op);
    logic [1:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/s8_wait_timer.sv
// Memory wait-state counter: counts cycles without acknowledge and flags the
// cycle in which the LIMIT-th unacknowledged cycle occurs.
module s8_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 32'd1);

  logic [7:0] count_r;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end
  end

  assign limit_reached = enable && (count_r == LIMIT_M1);

endmodule

// File: rtl/s8_control_unit.sv
// S8 accumulator-machine control unit: fetch/decode/memory-op sequencer with
// bounded memory wait and absorbing HALT/FAULT states.
module s8_control_unit
  import s8_control_unit_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] ir_in,
  input  logic       mem_ack,
  input  logic       zero_flag,
  output logic       load_ir,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       fault
);

  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] op_r;
  logic [3:0] op_nx_s;
  logic       waiting_s;
  logic       timeout_s;
  logic       unused_operand_s;

  // The operand address is routed to the datapath, not used for sequencing.
  assign unused_operand_s = ^ir_in[3:0];

  assign waiting_s = (state_r == ST_FETCH) || (state_r == ST_MEMOP);

  s8_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk           (clk),
    .reset         (reset),
    .clear         (!waiting_s || mem_ack),
    .enable        (waiting_s && !mem_ack),
    .limit_reached (timeout_s)
  );

  // Next-state and opcode-latch decode.
  always_comb begin
    state_nx_s = state_r;
    op_nx_s    = op_r;
    case (state_r)
      ST_IDLE:   state_nx_s = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nx_s = mem_ack ? ST_DECODE : (timeout_s ? ST_FAULT : ST_FETCH);
      ST_DECODE: begin
        op_nx_s = ir_in[7:4];
        case (ir_in[7:4])
          OP_NOP, OP_JMP, OP_JZ: state_nx_s = ST_FETCH;
          OP_HLT:                state_nx_s = ST_HALT;
          default:               state_nx_s = is_mem_op(ir_in[7:4]) ? ST_MEMOP : ST_FAULT;
        endcase
      end
      ST_MEMOP:  state_nx_s = mem_ack ? ST_FETCH : (timeout_s ? ST_FAULT : ST_MEMOP);
      ST_HALT:   state_nx_s = ST_HALT;
      ST_FAULT:  state_nx_s = ST_FAULT;
      default:   state_nx_s = ST_FAULT;
    endcase
  end

  // Ack- and decode-qualified strobes must respond in the same cycle.
  always_comb begin
    load_ir  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    case (state_r)
      ST_FETCH: begin
        load_ir = mem_ack;
        pc_inc  = mem_ack;
      end
      ST_DECODE: begin
        pc_load = (ir_in[7:4] == OP_JMP) || ((ir_in[7:4] == OP_JZ) && zero_flag);
      end
      ST_MEMOP: begin
        acc_load = mem_ack && (op_r != OP_STA);
        alu_op   = (mem_ack && (op_r != OP_STA)) ? alu_for(op_r) : ALU_PASS;
      end
      default: begin
        load_ir = 1'b0;
      end
    endcase
  end

  // State, latched opcode and the state-derived outputs, registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= 4'h0;
      addr_sel <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      op_r     <= op_nx_s;
      addr_sel <= (state_nx_s == ST_MEMOP);
      mem_rd   <= (state_nx_s == ST_FETCH) || ((state_nx_s == ST_MEMOP) && (op_nx_s != OP_STA));
      mem_wr   <= (state_nx_s == ST_MEMOP) && (op_nx_s == OP_STA);
      halted   <= (state_nx_s == ST_HALT);
      fault    <= (state_nx_s == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_s8_control_unit.sv
// Self-checking bench for s8_control_unit: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_s8_control_unit;
  import s8_control_unit_pkg::*;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] ir_in;
  logic       mem_ack;
  logic       zero_flag;
  logic       load_ir, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load, halted, fault;
  logic [1:0] alu_op;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  s8_control_unit #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .mem_ack(mem_ack),
    .zero_flag(zero_flag), .load_ir(load_ir), .pc_inc(pc_inc), .pc_load(pc_load),
    .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_load(acc_load),
    .alu_op(alu_op), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // {load_ir,pc_inc,pc_load,addr_sel,mem_rd,mem_wr,acc_load,alu_op,halted,fault}
  assign obs = {load_ir, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load, alu_op, halted, fault};

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Behavioural model: what the machine is doing, how long it has waited.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_MEM = 3, P_HALT = 4, P_FAULT = 5;
  int         m_mode;
  int         m_waited;
  logic [3:0] m_op;

  function automatic logic [10:0] model_out(input logic [7:0] ir, input logic ack, input logic zf);
    logic li, pi, pl, as_, rd, wr, al, h, f;
    logic [1:0] alu;
    {li, pi, pl, as_, rd, wr, al, h, f} = 9'b0;
    alu = 2'b00;
    case (m_mode)
      P_FETCH: begin rd = 1'b1; li = ack; pi = ack; end
      P_DEC:   pl = (ir[7:4] == 4'h5) || ((ir[7:4] == 4'h6) && zf);
      P_MEM: begin
        as_ = 1'b1;
        wr  = (m_op == 4'h2);
        rd  = !wr;
        al  = ack && !wr;
        if (al) alu = (m_op == 4'h3) ? 2'b01 : ((m_op == 4'h4) ? 2'b10 : 2'b00);
      end
      P_HALT:  h = 1'b1;
      P_FAULT: f = 1'b1;
      default: ;
    endcase
    return {li, pi, pl, as_, rd, wr, al, alu, h, f};
  endfunction

  task automatic model_step(input logic r, input logic [7:0] ir, input logic ack);
    int o;
    o = int'(ir[7:4]);
    case (m_mode)
      P_IDLE: if (r) begin m_mode = P_FETCH; m_waited = 0; end
      P_FETCH, P_MEM: begin
        if (ack) begin
          m_mode = (m_mode == P_FETCH) ? P_DEC : P_FETCH;
          m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited >= WL) m_mode = P_FAULT;
        end
      end
      P_DEC: begin
        if (o == 0 || o == 5 || o == 6) begin m_mode = P_FETCH; m_waited = 0; end
        else if (o == 15) m_mode = P_HALT;
        else if (o >= 1 && o <= 4) begin m_op = ir[7:4]; m_mode = P_MEM; m_waited = 0; end
        else m_mode = P_FAULT;
      end
      default: ;
    endcase
  endtask

  task automatic step(input string name, input logic r, input logic [7:0] ir, input logic ack, input logic zf);
    run = r; ir_in = ir; mem_ack = ack; zero_flag = zf;
    @(negedge clk);
    check(name, obs, model_out(ir, ack, zf));
    @(posedge clk);
    #1;
    model_step(r, ir, ack);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0; ir_in = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_mode = P_IDLE; m_waited = 0; m_op = 4'h0;
  endtask

  typedef struct {
    logic        r;
    logic [7:0]  ir;
    logic        ack;
    logic        zf;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [29];
  logic [3:0] pool [14];

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[5]  = '{1'b0, 8'h1A, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[6]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 11'b0001100_00_00};
    tbl[7]  = '{1'b0, 8'h2F, 1'b0, 1'b0, 11'b0001100_00_00};
    tbl[8]  = '{1'b0, 8'h1A, 1'b1, 1'b0, 11'b0001101_00_00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[10] = '{1'b0, 8'h63, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[12] = '{1'b0, 8'h63, 1'b0, 1'b1, 11'b0010000_00_00};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[14] = '{1'b0, 8'h55, 1'b0, 1'b0, 11'b0010000_00_00};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[16] = '{1'b0, 8'h3B, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[17] = '{1'b0, 8'h20, 1'b1, 1'b0, 11'b0001101_01_00};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[19] = '{1'b0, 8'h24, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[20] = '{1'b0, 8'h10, 1'b0, 1'b0, 11'b0001010_00_00};
    tbl[21] = '{1'b0, 8'h10, 1'b1, 1'b0, 11'b0001010_00_00};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[23] = '{1'b0, 8'h47, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[24] = '{1'b0, 8'h47, 1'b1, 1'b0, 11'b0001101_10_00};
    tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'b1100100_00_00};
    tbl[26] = '{1'b0, 8'hF0, 1'b0, 1'b0, 11'b0000000_00_00};
    tbl[27] = '{1'b1, 8'h00, 1'b1, 1'b0, 11'b0000000_00_10};
    tbl[28] = '{1'b1, 8'h1A, 1'b1, 1'b1, 11'b0000000_00_10};

    pool = '{OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ,
             OP_NOP, OP_LDA, OP_ADD, OP_JMP, OP_JZ, OP_HLT, 4'h9};

    reset = 1'b1; run = 1'b0; ir_in = 8'h00; mem_ack = 1'b0; zero_flag = 1'b0;
    m_mode = P_IDLE; m_waited = 0; m_op = 4'h0;
    @(posedge clk);
    #1;
    check("reset_state", obs, 11'b0);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      run = tbl[i].r; ir_in = tbl[i].ir; mem_ack = tbl[i].ack; zero_flag = tbl[i].zf;
      @(negedge clk);
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Fetch timeout: four unacknowledged cycles, then FAULT.
    do_reset();
    step("to_idle", 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < WL; i++) step("to_fetch_wait", 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check("fetch_timeout_fault", obs, 11'b0000000_00_01);

    // Acknowledge on the last allowed cycle completes normally.
    do_reset();
    step("al_idle", 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < WL - 1; i++) step("al_wait", 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("ack_at_limit", obs, 11'b1100100_00_00);
    @(posedge clk);
    #1;
    model_step(1'b0, 8'h00, 1'b1);
    step("al_decode", 1'b0, 8'h00, 1'b0, 1'b0);
    step("al_refetch", 1'b0, 8'h00, 1'b1, 1'b0);

    // MEMOP timeout.
    do_reset();
    step("mt_idle", 1'b1, 8'h00, 1'b0, 1'b0);
    step("mt_fetch", 1'b0, 8'h00, 1'b1, 1'b0);
    step("mt_decode", 1'b0, 8'h1A, 1'b0, 1'b0);
    for (int i = 0; i < WL; i++) step("mt_wait", 1'b0, 8'h1A, 1'b0, 1'b0);
    step("mt_fault", 1'b0, 8'h00, 1'b1, 1'b0);

    // Illegal opcode.
    do_reset();
    step("il_idle", 1'b1, 8'h00, 1'b0, 1'b0);
    step("il_fetch", 1'b0, 8'h00, 1'b1, 1'b0);
    step("il_decode", 1'b0, 8'h90, 1'b0, 1'b0);
    run = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check("illegal_fault", obs, 11'b0000000_00_01);

    // Asynchronous reset in the middle of a store.
    do_reset();
    step("rs_idle", 1'b1, 8'h00, 1'b0, 1'b0);
    step("rs_fetch", 1'b0, 8'h00, 1'b1, 1'b0);
    step("rs_decode", 1'b0, 8'h24, 1'b0, 1'b0);
    run = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("sta_wr_before_reset", obs, 11'b0001010_00_00);
    reset = 1'b1;
    #1;
    check("sta_reset_drop", obs, 11'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_mode = P_IDLE; m_waited = 0; m_op = 4'h0;
    step("late_ack_ignored", 1'b0, 8'h24, 1'b1, 1'b0);
    step("late_ack_idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [7:0] rir;
      rir = {pool[$urandom_range(0, 13)], 4'($urandom_range(0, 15))};
      if (((m_mode == P_HALT || m_mode == P_FAULT) && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 150) == 0) begin
        do_reset();
      end
      step("random", $urandom_range(0, 3) != 0, rir, $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
